// File: rtl/adc_stream_pkg.sv
// Shared definitions for the ADC sample stream: sample word layout, beat and FIFO entry
// geometry, and a saturating counter helper.
package adc_stream_pkg;

    localparam int unsigned SampleW    = 128;
    localparam int unsigned BeatW      = 64;
    localparam int unsigned EntryW     = SampleW + 1;
    localparam int unsigned LastBit    = EntryW - 1;

    localparam int unsigned CounterLsb = 64;
    localparam int unsigned CounterW   = 64;
    localparam int unsigned ChanALsb   = 48;
    localparam int unsigned ChanBLsb   = 32;
    localparam int unsigned SumLsb     = 16;
    localparam int unsigned MarkerLsb  = 0;
    localparam int unsigned MarkerW    = 16;

    localparam logic [MarkerW-1:0] MarkerDefault = 16'hA1B2;

    typedef enum logic {
        Beat0 = 1'b0,
        Beat1 = 1'b1
    } beat_sel_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous show-ahead FIFO. Besides the head entry it also exposes the entry behind the
// head so a consumer can move to the next entry on the same cycle it pops.
module sample_fifo #(
    parameter int unsigned WIDTH = 129,
    parameter int unsigned DEPTH = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [WIDTH-1:0]       rdata_next_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int unsigned AddrW  = $clog2(DEPTH);
    localparam int unsigned CountW = AddrW + 1;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [AddrW-1:0]  wptr_q, wptr_d;
    logic [AddrW-1:0]  rptr_q, rptr_d;
    logic [CountW-1:0] count_q, count_d;
    logic              do_push, do_pop;

    assign full_o       = (count_q == CountW'(DEPTH));
    assign empty_o      = (count_q == '0);
    assign count_o      = count_q;
    assign rdata_o      = mem_q[rptr_q];
    assign rdata_next_o = mem_q[rptr_q + AddrW'(1)];

    always_comb begin
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        wptr_d  = do_push ? wptr_q + AddrW'(1) : wptr_q;
        rptr_d  = do_pop ? rptr_q + AddrW'(1) : rptr_q;
        count_d = count_q + CountW'(do_push) - CountW'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/sample_packer.sv
// Packs 128-bit ADC sample words into a FIFO tagged with end-of-burst, then emits each entry as
// two 64-bit beats on an AXI-Stream style output, with drop/marker/burst statistics.
module sample_packer
    import adc_stream_pkg::*;
#(
    parameter int unsigned         DEPTH  = 256,
    parameter logic [MarkerW-1:0]  MARKER = MarkerDefault
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   s_axis_tvalid,
    input  logic [SampleW-1:0]     s_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [BeatW-1:0]       m_axis_tdata,
    output logic                   m_axis_tlast,
    input  logic                   clear_stats,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [31:0]            drop_count,
    output logic [31:0]            bursts_out,
    output logic [15:0]            marker_err_count,
    output logic                   overflow
);
    localparam int unsigned CountW = $clog2(DEPTH) + 1;

    logic               stage_vld_q, stage_vld_d;
    logic [SampleW-1:0] stage_data_q, stage_data_d;
    logic               pend_vld_q, pend_vld_d;
    logic [EntryW-1:0]  pend_entry_q, pend_entry_d;
    logic               out_vld_q, out_vld_d;
    logic               out_last_q, out_last_d;
    logic [BeatW-1:0]   out_data_q, out_data_d;
    beat_sel_e          beat_q, beat_d;
    logic [31:0]        drop_q, drop_d;
    logic [31:0]        bursts_q, bursts_d;
    logic [15:0]        merr_q, merr_d;
    logic               ovf_q, ovf_d;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic               drop, hs, marker_bad;
    logic [EntryW-1:0]  fifo_rdata, fifo_rdata_next;
    logic [CountW-1:0]  fifo_cnt;

    sample_fifo #(
        .WIDTH (EntryW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (aclk),
        .rst_i        (areset),
        .push_i       (fifo_push),
        .wdata_i      (pend_entry_q),
        .pop_i        (fifo_pop),
        .rdata_o      (fifo_rdata),
        .rdata_next_o (fifo_rdata_next),
        .count_o      (fifo_cnt),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    // The stage word learns whether it closes its burst from tvalid one cycle later.
    always_comb begin
        stage_vld_d  = s_axis_tvalid;
        stage_data_d = s_axis_tvalid ? s_axis_tdata : stage_data_q;
        pend_vld_d   = stage_vld_q;
        pend_entry_d = stage_vld_q ? {~s_axis_tvalid, stage_data_q} : pend_entry_q;
    end

    // The last free slot is kept for an end-of-burst entry.
    always_comb begin
        drop      = 1'b0;
        if (pend_vld_q) begin
            drop = pend_entry_q[LastBit] ? fifo_full : (fifo_cnt >= CountW'(DEPTH - 1));
        end
        fifo_push = pend_vld_q && !drop;
    end

    assign hs = out_vld_q && m_axis_tready;

    always_comb begin
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        beat_d     = beat_q;
        fifo_pop   = 1'b0;
        if (!out_vld_q) begin
            if (!fifo_empty) begin
                out_vld_d  = 1'b1;
                out_data_d = fifo_rdata[BeatW +: BeatW];
                out_last_d = 1'b0;
                beat_d     = Beat0;
            end
        end else if (hs) begin
            if (beat_q == Beat0) begin
                out_data_d = fifo_rdata[0 +: BeatW];
                out_last_d = fifo_rdata[LastBit];
                beat_d     = Beat1;
            end else begin
                fifo_pop   = 1'b1;
                beat_d     = Beat0;
                out_last_d = 1'b0;
                // Head is being popped; the entry behind it is only readable if it already exists.
                if (fifo_cnt >= CountW'(2)) begin
                    out_data_d = fifo_rdata_next[BeatW +: BeatW];
                end else begin
                    out_vld_d = 1'b0;
                end
            end
        end
    end

    always_comb begin
        marker_bad = s_axis_tvalid && (s_axis_tdata[MarkerLsb +: MarkerW] != MARKER);
        drop_d     = drop ? sat_inc32(drop_q) : drop_q;
        ovf_d      = ovf_q | drop;
        bursts_d   = (hs && out_last_q) ? bursts_q + 32'd1 : bursts_q;
        merr_d     = (marker_bad && !(&merr_q)) ? merr_q + 16'd1 : merr_q;
        if (clear_stats) begin
            drop_d   = '0;
            ovf_d    = 1'b0;
            bursts_d = '0;
            merr_d   = '0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            stage_vld_q  <= 1'b0;
            stage_data_q <= '0;
            pend_vld_q   <= 1'b0;
            pend_entry_q <= '0;
            out_vld_q    <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            beat_q       <= Beat0;
            drop_q       <= '0;
            bursts_q     <= '0;
            merr_q       <= '0;
            ovf_q        <= 1'b0;
        end else begin
            stage_vld_q  <= stage_vld_d;
            stage_data_q <= stage_data_d;
            pend_vld_q   <= pend_vld_d;
            pend_entry_q <= pend_entry_d;
            out_vld_q    <= out_vld_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            beat_q       <= beat_d;
            drop_q       <= drop_d;
            bursts_q     <= bursts_d;
            merr_q       <= merr_d;
            ovf_q        <= ovf_d;
        end
    end

    assign m_axis_tvalid    = out_vld_q;
    assign m_axis_tdata     = out_data_q;
    assign m_axis_tlast     = out_last_q;
    assign fifo_count       = fifo_cnt;
    assign drop_count       = drop_q;
    assign bursts_out       = bursts_q;
    assign marker_err_count = merr_q;
    assign overflow         = ovf_q;

endmodule

// File: tb/tb_sample_packer.sv
// Randomized and directed bench for sample_packer against a queue-based reference model.
module tb_sample_packer;
    localparam int unsigned Depth  = 4;
    localparam logic [15:0] Marker = 16'hA1B2;

    typedef struct {
        logic [63:0] data;
        bit          last;
        bit          b1;
    } beat_t;

    logic         clk;
    logic         areset;
    logic         s_axis_tvalid;
    logic [127:0] s_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic [63:0]  m_axis_tdata;
    logic         m_axis_tlast;
    logic         clear_stats;
    logic [2:0]   fifo_count;
    logic [31:0]  drop_count;
    logic [31:0]  bursts_out;
    logic [15:0]  marker_err_count;
    logic         overflow;

    sample_packer #(
        .DEPTH  (Depth),
        .MARKER (Marker)
    ) dut (
        .aclk             (clk),
        .areset           (areset),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tdata     (s_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tlast     (m_axis_tlast),
        .clear_stats      (clear_stats),
        .fifo_count       (fifo_count),
        .drop_count       (drop_count),
        .bursts_out       (bursts_out),
        .marker_err_count (marker_err_count),
        .overflow         (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    beat_t       exp_q[$];
    beat_t       log_q[$];
    int unsigned m_count;
    logic [31:0] m_drop, m_bursts;
    logic [15:0] m_merr;
    bit          m_ovf;
    // Input history: word seen one and two edges ago.
    bit          h_new_v, h_old_v;
    logic [127:0] h_new_d, h_old_d;
    bit          prev_stall, rst_seen;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [127:0] act);
        checks++;
        errors++;
        $display("FAIL %s at %0t: got %0h", name, $time, act);
    endtask

    function automatic logic [127:0] mkw(input logic [63:0] c, input logic [15:0] mk);
        logic [15:0] a, b;
        a = 16'h1000 + c[15:0];
        b = 16'h2000 + c[15:0];
        return {c, a, b, a + b, mk};
    endfunction

    // Advance the reference model across the coming clock edge.
    task automatic model_edge();
        beat_t e;
        bit    hs, pop, lastf, drp;
        prev_stall = 1'b0;
        rst_seen   = areset;
        if (areset) begin
            exp_q.delete();
            m_count = 0; m_drop = '0; m_bursts = '0; m_merr = '0; m_ovf = 1'b0;
            h_new_v = 1'b0; h_old_v = 1'b0;
            return;
        end
        hs         = m_axis_tvalid && m_axis_tready;
        prev_stall = m_axis_tvalid && !m_axis_tready;
        pop        = 1'b0;
        if (hs) begin
            log_q.push_back('{data: m_axis_tdata, last: m_axis_tlast, b1: 1'b0});
            if (exp_q.size() == 0) begin
                fail("spurious_beat", 128'(m_axis_tdata));
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", 128'(m_axis_tdata), 128'(e.data));
                chk("beat_last", 128'(m_axis_tlast), 128'(e.last));
                pop = e.b1;
                if (e.last) m_bursts++;
            end
        end
        if (h_old_v) begin
            lastf = !h_new_v;
            drp   = lastf ? (m_count == Depth) : (m_count >= Depth - 1);
            if (drp) begin
                if (m_drop != '1) m_drop++;
                m_ovf = 1'b1;
            end else begin
                exp_q.push_back('{data: h_old_d[127:64], last: 1'b0, b1: 1'b0});
                exp_q.push_back('{data: h_old_d[63:0], last: lastf, b1: 1'b1});
                m_count++;
            end
        end
        if (pop) m_count--;
        if (s_axis_tvalid && s_axis_tdata[15:0] != Marker && m_merr != '1) m_merr++;
        if (clear_stats) begin
            m_drop = '0; m_bursts = '0; m_merr = '0; m_ovf = 1'b0;
        end
        h_old_v = h_new_v;
        h_old_d = h_new_d;
        h_new_v = s_axis_tvalid;
        h_new_d = s_axis_tdata;
    endtask

    task automatic post_check();
        chk("fifo_count", 128'(fifo_count), 128'(m_count));
        chk("drop_count", 128'(drop_count), 128'(m_drop));
        chk("bursts_out", 128'(bursts_out), 128'(m_bursts));
        chk("marker_err_count", 128'(marker_err_count), 128'(m_merr));
        chk("overflow", 128'(overflow), 128'(m_ovf));
        if (rst_seen) begin
            chk("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
            chk("rst_tdata", 128'(m_axis_tdata), 128'(0));
            chk("rst_tlast", 128'(m_axis_tlast), 128'(0));
        end
        if (prev_stall) chk("stall_hold_valid", 128'(m_axis_tvalid), 128'(1));
        if (m_axis_tvalid) begin
            if (exp_q.size() == 0) begin
                fail("valid_without_data", 128'(m_axis_tdata));
            end else begin
                chk("out_data", 128'(m_axis_tdata), 128'(exp_q[0].data));
                chk("out_last", 128'(m_axis_tlast), 128'(exp_q[0].last));
            end
        end
    endtask

    task automatic cyc(input bit v, input logic [127:0] d, input bit rdy, input bit clr,
                       input bit rst);
        @(negedge clk);
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        m_axis_tready = rdy;
        clear_stats   = clr;
        areset        = rst;
        #1;
        model_edge();
        @(posedge clk);
        #1;
        post_check();
    endtask

    task automatic drain(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && m_count == 0 && !h_new_v && !h_old_v && !m_axis_tvalid)
                break;
            cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        if (i == budget) fail("drain_timeout", 128'(exp_q.size()));
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        int          lat;
        bit          inb;
        bit          r, c, rs;
        logic [127:0] w;

        s_axis_tvalid = 1'b0; s_axis_tdata = '0; m_axis_tready = 1'b0;
        clear_stats = 1'b0; areset = 1'b1;
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
        chk("reset_fifo_count", 128'(fifo_count), 128'(0));
        idle(2, 1'b1);

        // Three-word burst, ready held high.
        log_q.delete();
        for (int i = 0; i < 3; i++) cyc(1'b1, mkw(64'(10 + i), Marker), 1'b1, 1'b0, 1'b0);
        drain(100);
        chk("b3_beats", 128'(log_q.size()), 128'(6));
        if (log_q.size() == 6) begin
            chk("b3_beat0", 128'(log_q[0].data), 128'(64'd10));
            chk("b3_beat1", 128'(log_q[1].data), 128'(64'h100A_200A_3014_A1B2));
            chk("b3_beat2", 128'(log_q[2].data), 128'(64'd11));
            chk("b3_beat3", 128'(log_q[3].data), 128'(64'h100B_200B_3016_A1B2));
            chk("b3_beat4", 128'(log_q[4].data), 128'(64'd12));
            chk("b3_beat5", 128'(log_q[5].data), 128'(64'h100C_200C_3018_A1B2));
            for (int i = 0; i < 6; i++) chk("b3_tlast", 128'(log_q[i].last), 128'(i == 5));
        end
        chk("b3_bursts", 128'(bursts_out), 128'(1));
        chk("b3_drops", 128'(drop_count), 128'(0));

        // Single-word burst: first beat three edges after capture.
        log_q.delete();
        cyc(1'b1, mkw(64'h55, Marker), 1'b1, 1'b0, 1'b0);
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
            lat++;
            if (m_axis_tvalid) break;
        end
        chk("single_latency", 128'(lat), 128'(3));
        drain(100);
        chk("single_beats", 128'(log_q.size()), 128'(2));
        if (log_q.size() == 2) begin
            chk("single_beat0", 128'(log_q[0].data), 128'(64'h55));
            chk("single_last0", 128'(log_q[0].last), 128'(0));
            chk("single_last1", 128'(log_q[1].last), 128'(1));
        end

        // Overflow with the reserved slot: 10 words into a depth-4 FIFO, ready low.
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, mkw(64'(100 + i), Marker), 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);
        chk("ovf_fifo_count", 128'(fifo_count), 128'(4));
        chk("ovf_drops", 128'(drop_count), 128'(6));
        chk("ovf_flag", 128'(overflow), 128'(1));
        log_q.delete();
        drain(100);
        chk("ovf_beats", 128'(log_q.size()), 128'(8));
        if (log_q.size() == 8) begin
            chk("ovf_first", 128'(log_q[0].data), 128'(64'd100));
            chk("ovf_reserved", 128'(log_q[6].data), 128'(64'd109));
            for (int i = 0; i < 8; i++) chk("ovf_tlast", 128'(log_q[i].last), 128'(i == 7));
        end

        // Ready toggling during a four-word burst.
        log_q.delete();
        for (int i = 0; i < 4; i++) cyc(1'b1, mkw(64'(200 + i), Marker), (i % 2) == 0, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) cyc(1'b0, '0, (i % 2) == 0, 1'b0, 1'b0);
        drain(100);
        chk("toggle_beats", 128'(log_q.size()), 128'(8));

        // Bad marker is forwarded and counted; clear keeps FIFO contents.
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
        log_q.delete();
        cyc(1'b1, mkw(64'd300, Marker), 1'b1, 1'b0, 1'b0);
        cyc(1'b1, mkw(64'd301, 16'h0000), 1'b1, 1'b0, 1'b0);
        cyc(1'b1, mkw(64'd302, Marker), 1'b1, 1'b0, 1'b0);
        drain(100);
        chk("merr_count", 128'(marker_err_count), 128'(1));
        if (log_q.size() == 6)
            chk("merr_fwd", 128'(log_q[3].data), 128'(64'h112D_212D_325A_0000));
        else
            fail("merr_beats", 128'(log_q.size()));
        cyc(1'b1, mkw(64'd310, Marker), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, mkw(64'd311, Marker), 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("clr_fifo_count", 128'(fifo_count), 128'(2));
        chk("clr_drops", 128'(drop_count), 128'(0));
        chk("clr_bursts", 128'(bursts_out), 128'(0));
        chk("clr_merr", 128'(marker_err_count), 128'(0));
        chk("clr_ovf", 128'(overflow), 128'(0));
        drain(100);

        // Reset while beat1 is pending.
        cyc(1'b1, mkw(64'd400, Marker), 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);
        idle(1, 1'b1);
        idle(1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("midrst_tvalid", 128'(m_axis_tvalid), 128'(0));
        chk("midrst_fifo_count", 128'(fifo_count), 128'(0));
        log_q.delete();
        cyc(1'b1, mkw(64'h77, Marker), 1'b1, 1'b0, 1'b0);
        drain(100);
        chk("postrst_beats", 128'(log_q.size()), 128'(2));
        if (log_q.size() == 2) begin
            chk("postrst_beat0", 128'(log_q[0].data), 128'(64'h77));
            chk("postrst_last", 128'(log_q[1].last), 128'(1));
        end

        // Random bursts, backpressure, clears and resets.
        inb = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if (inb) inb = ($urandom_range(0, 7) != 0);
            else     inb = ($urandom_range(0, 3) == 0);
            w = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 9) != 0) w[15:0] = Marker;
            if (((n / 500) % 2) == 1) r = ($urandom_range(0, 3) == 0);
            else                      r = ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 199) == 0);
            rs = ($urandom_range(0, 499) == 0);
            cyc(inb, w, r, c, rs);
        end
        drain(400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
